// File: rtl/clint_rtc_gen_if.sv
// Bus bundle for the CLINT RTC generator: control inputs, external pin and
// generated outputs. The testbench or the parent drives the master side.
interface clint_rtc_gen_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 en_i;
  logic                 ext_sel_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic                 ext_rtc_i;
  logic                 rtc_clk_o;
  logic                 tick_o;
  logic                 sel_o;

  modport master (
    output en_i, ext_sel_i, div_i, ext_rtc_i,
    input  rtc_clk_o, tick_o, sel_o
  );

  modport slave (
    input  en_i, ext_sel_i, div_i, ext_rtc_i,
    output rtc_clk_o, tick_o, sel_o
  );
endinterface

// File: rtl/clint_rtc_gen.sv
// RTC clock generator for the CLINT mtime counter. Produces a registered
// square wave from either a programmable divider of clk_i or a synchronised,
// deglitched external RTC pin, with a glitch-free source switch.
module clint_rtc_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  clint_rtc_gen_if.slave  bus
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   int_lvl_q, int_lvl_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   ext_lvl_q, ext_lvl_d;
  logic                   sel_q, sel_d;
  logic                   rtc_q, rtc_d;
  logic                   tick_q, tick_d;
  logic                   synced;
  logic                   new_lvl;

  assign synced = sync_q[SYNC_STAGES-1];

  // Internal divider: half-period of div_q+1 cycles, reload only at a toggle
  // or while disabled so a div_i change never shortens the running half.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    int_lvl_d = int_lvl_q;
    if (!bus.en_i) begin
      cnt_d     = '0;
      int_lvl_d = 1'b0;
      div_d     = bus.div_i;
    end else if (cnt_q == div_q) begin
      cnt_d     = '0;
      int_lvl_d = ~int_lvl_q;
      div_d     = bus.div_i;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // External path: synchroniser plus a run-length filter. An undefined synced
  // value makes the inequality unknown, which falls into the clear branch, so
  // ext_lvl holds until the pin settles to a defined level.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.ext_rtc_i};
    fcnt_d    = '0;
    ext_lvl_d = ext_lvl_q;
    if (synced != ext_lvl_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) begin
        ext_lvl_d = synced;
        fcnt_d    = '0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Source switch and output stage. The switch looks at pre-toggle levels and
  // only commits while both the output and the requested source are low.
  always_comb begin
    new_lvl = bus.ext_sel_i ? ext_lvl_q : int_lvl_q;
    sel_d   = sel_q;
    if ((bus.ext_sel_i != sel_q) && !rtc_q && !new_lvl) begin
      sel_d = bus.ext_sel_i;
    end
    rtc_d  = bus.en_i & (sel_q ? ext_lvl_q : int_lvl_q);
    tick_d = bus.en_i & rtc_d & ~rtc_q;
  end

  // State registers. Reset reloads div_q from div_i, like the disabled state,
  // so the first half-period after release is a full div_i+1 cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      div_q     <= bus.div_i;
      int_lvl_q <= 1'b0;
      sync_q    <= '0;
      fcnt_q    <= '0;
      ext_lvl_q <= 1'b0;
      sel_q     <= 1'b0;
      rtc_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      int_lvl_q <= int_lvl_d;
      sync_q    <= sync_d;
      fcnt_q    <= fcnt_d;
      ext_lvl_q <= ext_lvl_d;
      sel_q     <= sel_d;
      rtc_q     <= rtc_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.rtc_clk_o = rtc_q;
  assign bus.tick_o    = tick_q;
  assign bus.sel_o     = sel_q;

endmodule
